// File: rtl/memory_map_mp_if.sv
// Bus port bundle for one side (A or B) of memory_map_mp.
interface memory_map_mp_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   data;
    logic                    we;
    logic [DATA_WIDTH/8-1:0] be;
    logic [DATA_WIDTH-1:0]   q;

    modport master (output addr, output data, output we, output be, input q);
    modport slave  (input addr, input data, input we, input be, output q);
endinterface

// File: rtl/memory_map_mp.sv
// Dual-port memory map: NUM_REGS MMIO registers, a read-only STATUS word and a
// byte-enabled SRAM, reachable from both ports with read-first semantics.
// Optional feature macro: MEMORY_MAP_PARITY_EN (per-byte even parity on SRAM).
module memory_map_mp #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned NUM_REGS   = 14,
    parameter int unsigned REG_BASE   = 'h000,
    parameter int unsigned REG_STRIDE = 'h100,
    parameter int unsigned SRAM_DEPTH = 2**ADDR_WIDTH,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    memory_map_mp_if.slave                 port_a,
    memory_map_mp_if.slave                 port_b,
    output logic                           collision_o,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out_o,
    output logic                           parity_err_o
);
    localparam int unsigned NB  = DATA_WIDTH / 8;
    localparam int unsigned SAW = $clog2(SRAM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR = ADDR_WIDTH'(REG_BASE + NUM_REGS * REG_STRIDE);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [DATA_WIDTH-1:0] mem    [SRAM_DEPTH];
`ifdef MEMORY_MAP_PARITY_EN
    logic [NB-1:0]         par_mem [SRAM_DEPTH];
`endif

    logic [NUM_REGS-1:0]   hit_a, hit_b;
    logic                  st_a, st_b, sr_a, sr_b;
    logic [SAW-1:0]        idx_a, idx_b;
    logic                  same_tgt, coll_c, clr_c;
    logic                  perr_a, perr_b;
    logic [15:0]           coll_cnt_q, coll_cnt_d, par_cnt_q, par_cnt_d;
    logic [DATA_WIDTH-1:0] rd_a, rd_b, status_w;
    logic [DATA_WIDTH-1:0] q1_a_q, q1_b_q, q_a_q, q_b_q;
    logic                  perr1_q, perr_q, collision_q;

    function automatic logic [NUM_REGS-1:0] reg_hit(input logic [ADDR_WIDTH-1:0] addr);
        logic [NUM_REGS-1:0] h;
        h = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++)
            if (addr == ADDR_WIDTH'(REG_BASE + i * REG_STRIDE)) h[i] = 1'b1;
        return h;
    endfunction

`ifdef MEMORY_MAP_PARITY_EN
    function automatic logic [NB-1:0] byte_par(input logic [DATA_WIDTH-1:0] w);
        logic [NB-1:0] p;
        for (int unsigned b = 0; b < NB; b++) p[b] = ^w[8*b +: 8];
        return p;
    endfunction
`endif

    // Address decode for both ports
    always_comb begin
        hit_a = reg_hit(port_a.addr);
        hit_b = reg_hit(port_b.addr);
        st_a  = (port_a.addr == STATUS_ADDR);
        st_b  = (port_b.addr == STATUS_ADDR);
        sr_a  = ~(|hit_a) & ~st_a;
        sr_b  = ~(|hit_b) & ~st_b;
        idx_a = port_a.addr[SAW-1:0];
        idx_b = port_b.addr[SAW-1:0];
    end

    // Read mux and parity check on the pre-write (read-first) contents
    always_comb begin
        status_w = DATA_WIDTH'({par_cnt_q, coll_cnt_q});
        rd_a = mem[idx_a];
        rd_b = mem[idx_b];
        if (st_a) rd_a = status_w;
        if (st_b) rd_b = status_w;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (hit_a[i]) rd_a = regs_q[i];
            if (hit_b[i]) rd_b = regs_q[i];
        end
`ifdef MEMORY_MAP_PARITY_EN
        perr_a = sr_a & (|(byte_par(mem[idx_a]) ^ par_mem[idx_a]));
        perr_b = sr_b & (|(byte_par(mem[idx_b]) ^ par_mem[idx_b]));
`else
        perr_a = 1'b0;
        perr_b = 1'b0;
`endif
    end

    // Register merge (A wins overlapping lanes), collision detect, STATUS counters
    always_comb begin
        same_tgt = (|(hit_a & hit_b)) | (sr_a & sr_b & (idx_a == idx_b));
        coll_c   = port_a.we & port_b.we & same_tgt & (|(port_a.be & port_b.be));
        clr_c    = (port_a.we & st_a) | (port_b.we & st_b);
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            for (int unsigned b = 0; b < NB; b++) begin
                if (port_b.we & hit_b[i] & port_b.be[b]) regs_d[i][8*b +: 8] = port_b.data[8*b +: 8];
                if (port_a.we & hit_a[i] & port_a.be[b]) regs_d[i][8*b +: 8] = port_a.data[8*b +: 8];
            end
        end
        coll_cnt_d = clr_c ? 16'h0 : coll_cnt_q;
        if (coll_c && coll_cnt_d != 16'hFFFF) coll_cnt_d = coll_cnt_d + 16'd1;
        par_cnt_d = clr_c ? 16'h0 : par_cnt_q;
        if (perr_a && par_cnt_d != 16'hFFFF) par_cnt_d = par_cnt_d + 16'd1;
        if (perr_b && par_cnt_d != 16'hFFFF) par_cnt_d = par_cnt_d + 16'd1;
    end

    // SRAM write; port A is applied last so it wins overlapping lanes
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (port_b.we & sr_b & port_b.be[b]) begin
                    mem[idx_b][8*b +: 8] <= port_b.data[8*b +: 8];
`ifdef MEMORY_MAP_PARITY_EN
                    par_mem[idx_b][b] <= ^port_b.data[8*b +: 8];
`endif
                end
            end
            for (int unsigned b = 0; b < NB; b++) begin
                if (port_a.we & sr_a & port_a.be[b]) begin
                    mem[idx_a][8*b +: 8] <= port_a.data[8*b +: 8];
`ifdef MEMORY_MAP_PARITY_EN
                    par_mem[idx_a][b] <= ^port_a.data[8*b +: 8];
`endif
                end
            end
        end
    end

    // Registers, counters, collision pulse and first read stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            coll_cnt_q  <= '0;
            par_cnt_q   <= '0;
            collision_q <= 1'b0;
            q1_a_q      <= '0;
            q1_b_q      <= '0;
            perr1_q     <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
            coll_cnt_q  <= coll_cnt_d;
            par_cnt_q   <= par_cnt_d;
            collision_q <= coll_c;
            q1_a_q      <= rd_a;
            q1_b_q      <= rd_b;
            perr1_q     <= perr_a | perr_b;
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            // Extra output stage for two-cycle read latency
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q_a_q  <= '0;
                    q_b_q  <= '0;
                    perr_q <= 1'b0;
                end else begin
                    q_a_q  <= q1_a_q;
                    q_b_q  <= q1_b_q;
                    perr_q <= perr1_q;
                end
            end
        end else begin : g_lat1
            assign q_a_q  = q1_a_q;
            assign q_b_q  = q1_b_q;
            assign perr_q = perr1_q;
        end
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_regout
            assign reg_out_o[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
        end
    endgenerate

    assign port_a.q     = q_a_q;
    assign port_b.q     = q_b_q;
    assign collision_o  = collision_q;
    assign parity_err_o = perr_q;
endmodule
